seg_scan_capture: RTL and testbench

- Monitors the multiplexed 8-digit 7-segment bus (cs/segment lines) driven by the clock display path and reconstructs the displayed frame.
- Outputs per-position BCD codes, decimal-point mask and decoded HH/MM/SS with a frame-valid strobe.
- Serves as an on-chip readback and self-check of the display path, and as the scoreboard front end in the display benches.

---
 rtl/seg_scan_pkg.sv | 34 +++
 rtl/seg_scan_capture_glyph_decoder.sv | 28 ++
 rtl/seg_scan_capture.sv | 200 ++++++++++++++++++++
 tb/tb_seg_scan_capture.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan capture block.
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_e;

   // Active-high segment patterns, bit0=a .. bit6=g
   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_BAD   = 4'hE;

   localparam logic [6:0] MAX_HH   = 7'd23;
   localparam logic [6:0] MAX_MMSS = 7'd59;

   // Binary value of a tens/ones digit pair; only meaningful when both are 0-9
   function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
      return (7'(tens) * 7'd10) + 7'(ones);
   endfunction

endpackage

// File: rtl/seg_scan_capture_glyph_decoder.sv
// Maps an active-high 7-segment pattern to its digit code (0-9, F=blank, E=bad).
module seg_glyph_decoder
   import seg_scan_pkg::*;
(
   input  logic [6:0] glyph,
   output logic [3:0] code
);

   // Pure lookup; anything that is not a recognised glyph is flagged bad
   always_comb begin
      code = CODE_BAD;
      case (glyph)
         GLYPH_0:     code = 4'd0;
         GLYPH_1:     code = 4'd1;
         GLYPH_2:     code = 4'd2;
         GLYPH_3:     code = 4'd3;
         GLYPH_4:     code = 4'd4;
         GLYPH_5:     code = 4'd5;
         GLYPH_6:     code = 4'd6;
         GLYPH_7:     code = 4'd7;
         GLYPH_8:     code = 4'd8;
         GLYPH_9:     code = 4'd9;
         GLYPH_BLANK: code = CODE_BLANK;
         default:     code = CODE_BAD;
      endcase
   end

endmodule

// File: rtl/seg_scan_capture.sv
// Reconstructs the displayed HH:MM:SS frame from the multiplexed 7-segment bus.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cs is not exactly one-hot, nothing to sample
// SETTLE | one digit selected, waiting for cs/seg to be stable long enough
// HOLD   | this activation already sampled, waiting for cs or seg to move
module seg_scan_capture
   import seg_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int CS_ACTIVE_LOW  = 1,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cs_in,
   input  logic [7:0]  seg_in,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [31:0] digits,
   output logic [7:0]  dp,
   output logic [4:0]  hh,
   output logic [5:0]  mm,
   output logic [5:0]  ss,
   output logic        stale
);

   localparam int STW = $clog2(SETTLE_CYCLES + 1);
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STW-1:0] SETTLE_MAX = STW'(SETTLE_CYCLES);
   localparam logic [TW-1:0]  TO_MAX     = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TO_HIT     = TW'(TIMEOUT_CYCLES - 1);
   // Idle bus levels, so reset does not look like every digit being selected
   localparam logic [7:0] CS_IDLE_RAW  = (CS_ACTIVE_LOW != 0)  ? 8'hFF : 8'h00;
   localparam logic [7:0] SEG_IDLE_RAW = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [7:0]     cs_s1, cs_s2, seg_s1, seg_s2;
   logic [7:0]     cs_prev, seg_prev;
   logic [7:0]     cs_act, seg_act;
   logic           changed, cs_onehot;
   logic [2:0]     pos;
   logic [STW-1:0] stab_cnt;
   logic [TW-1:0]  to_cnt;
   scan_state_e    state, state_nxt;
   logic           sample, timeout_hit, frame_done, frame_good;
   logic [3:0]     glyph_code;
   logic [7:0]     seen, seen_nxt;
   logic [31:0]    sh_code, sh_code_nxt;
   logic [7:0]     sh_dp, sh_dp_nxt;
   logic [6:0]     hh_v, mm_v, ss_v;
   logic           codes_ok;

   // Two-flop synchronizers plus a one-cycle history for change detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_s1    <= CS_IDLE_RAW;
         cs_s2    <= CS_IDLE_RAW;
         cs_prev  <= CS_IDLE_RAW;
         seg_s1   <= SEG_IDLE_RAW;
         seg_s2   <= SEG_IDLE_RAW;
         seg_prev <= SEG_IDLE_RAW;
      end else begin
         cs_s1    <= cs_in;
         cs_s2    <= cs_s1;
         cs_prev  <= cs_s2;
         seg_s1   <= seg_in;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
      end
   end

   assign cs_act    = (CS_ACTIVE_LOW != 0)  ? ~cs_s2  : cs_s2;
   assign seg_act   = (SEG_ACTIVE_LOW != 0) ? ~seg_s2 : seg_s2;
   assign changed   = (cs_s2 != cs_prev) || (seg_s2 != seg_prev);
   assign cs_onehot = (cs_act != 8'h00) && ((cs_act & (cs_act - 8'h01)) == 8'h00);

   // Selected position index; only used when cs is one-hot
   always_comb begin
      pos = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (cs_act[i]) pos = 3'(i);
      end
   end

   // Stability counter: cleared on any bus change, saturates at the settle target
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_cnt <= '0;
      end else if (changed) begin
         stab_cnt <= '0;
      end else if (stab_cnt != SETTLE_MAX) begin
         stab_cnt <= stab_cnt + 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and the sample strobe; a changing bus never samples
   always_comb begin
      state_nxt = state;
      sample    = 1'b0;
      case (state)
         IDLE: begin
            if (cs_onehot) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!cs_onehot) begin
               state_nxt = IDLE;
            end else if (!changed && (stab_cnt == SETTLE_MAX)) begin
               sample    = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (changed) state_nxt = cs_onehot ? SETTLE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   seg_glyph_decoder u_glyph (
      .glyph (seg_act[6:0]),
      .code  (glyph_code)
   );

   assign timeout_hit = (to_cnt == TO_HIT);
   assign frame_done  = (seen == 8'hFF);

   // Shadow/mask update; a sample coinciding with completion or timeout keeps its own entry
   always_comb begin
      seen_nxt    = (frame_done || timeout_hit) ? 8'h00 : seen;
      sh_code_nxt = timeout_hit ? 32'hFFFF_FFFF : sh_code;
      sh_dp_nxt   = timeout_hit ? 8'h00 : sh_dp;
      if (sample) begin
         seen_nxt[pos]                = 1'b1;
         sh_code_nxt[{pos, 2'b00} +: 4] = glyph_code;
         sh_dp_nxt[pos]               = seg_act[7];
      end
   end

   assign hh_v = bcd_pair(sh_code[3:0],   sh_code[7:4]);
   assign mm_v = bcd_pair(sh_code[15:12], sh_code[19:16]);
   assign ss_v = bcd_pair(sh_code[27:24], sh_code[31:28]);

   // Separator positions 2 and 5 are free; every other position must be a digit
   assign codes_ok = (sh_code[3:0]   <= 4'd9) && (sh_code[7:4]   <= 4'd9) &&
                     (sh_code[15:12] <= 4'd9) && (sh_code[19:16] <= 4'd9) &&
                     (sh_code[27:24] <= 4'd9) && (sh_code[31:28] <= 4'd9);
   assign frame_good = codes_ok && (hh_v <= MAX_HH) && (mm_v <= MAX_MMSS) && (ss_v <= MAX_MMSS);

   // Frame shadow, seen mask and the no-sample timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen    <= 8'h00;
         sh_code <= 32'hFFFF_FFFF;
         sh_dp   <= 8'h00;
         to_cnt  <= '0;
      end else begin
         seen    <= seen_nxt;
         sh_code <= sh_code_nxt;
         sh_dp   <= sh_dp_nxt;
         if (sample)                to_cnt <= '0;
         else if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
      end
   end

   // Published frame: loads only on a good frame, status pulses on every completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         digits      <= 32'hFFFF_FFFF;
         dp          <= 8'h00;
         hh          <= '0;
         mm          <= '0;
         ss          <= '0;
         stale       <= 1'b1;
      end else begin
         frame_valid <= frame_done && frame_good;
         frame_err   <= frame_done && !frame_good;
         if (frame_done && frame_good) begin
            digits <= sh_code;
            dp     <= sh_dp;
            hh     <= hh_v[4:0];
            mm     <= mm_v[5:0];
            ss     <= ss_v[5:0];
            stale  <= 1'b0;
         end else if (timeout_hit) begin
            stale  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture: table vectors, random frames, corner sequences.
module tb_seg_scan_capture;

   localparam int SETTLE = 16;
   localparam int TMO    = 2000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cs_in, seg_in;
   logic        frame_valid, frame_err, stale;
   logic [31:0] digits;
   logic [7:0]  dp;
   logic [4:0]  hh;
   logic [5:0]  mm, ss;

   seg_scan_capture #(
      .SETTLE_CYCLES  (SETTLE),
      .TIMEOUT_CYCLES (TMO),
      .CS_ACTIVE_LOW  (1),
      .SEG_ACTIVE_LOW (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cs_in       (cs_in),
      .seg_in      (seg_in),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .digits      (digits),
      .dp          (dp),
      .hh          (hh),
      .mm          (mm),
      .ss          (ss),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   logic [6:0] glyph_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                   7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int n_checks = 0;
   int n_err    = 0;
   int nv = 0, ne = 0, n_both = 0;

   // Pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid) nv++;
         if (frame_err) ne++;
         if (frame_valid && frame_err) n_both++;
      end
   end

   // Frame currently being displayed by the bench
   logic [31:0] fr_code;
   logic [7:0]  fr_dp;
   logic [6:0]  fr_bad;

   // Expected published outputs
   logic [31:0] exp_digits;
   logic [7:0]  exp_dp;
   int          exp_hh, exp_mm, exp_ss;
   logic        exp_stale;

   typedef struct {
      logic [31:0] code;
      logic [7:0]  dpm;
      logic [6:0]  bad;
      bit          ok;
      int          h, m, s;
   } vec_t;
   vec_t vecs [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
      end
   endtask

   function automatic logic [6:0] pat_of(input logic [3:0] c);
      if (c <= 4'd9)  return glyph_tab[c];
      if (c == 4'hF)  return 7'h00;
      return fr_bad;
   endfunction

   task automatic drive_pos(input int p, input logic [6:0] pat, input logic d, input int cyc);
      cs_in  = ~(8'h01 << p);
      seg_in = ~{d, pat};
      repeat (cyc) @(negedge clk);
   endtask

   task automatic scan(input int start, input int n, input int dwell);
      for (int k = 0; k < n; k++) begin
         int p;
         p = (start + k) % 8;
         drive_pos(p, pat_of(fr_code[p*4 +: 4]), fr_dp[p], dwell);
      end
   endtask

   task automatic idle(input int cyc);
      cs_in  = 8'hFF;
      seg_in = 8'hFF;
      repeat (cyc) @(negedge clk);
   endtask

   // Reference model: read the frame as a clock display would
   task automatic model(input logic [31:0] c, output bit ok, output int h, output int m, output int s);
      int d [8];
      for (int i = 0; i < 8; i++) d[i] = int'(c[i*4 +: 4]);
      h  = 10 * d[0] + d[1];
      m  = 10 * d[3] + d[4];
      s  = 10 * d[6] + d[7];
      ok = (h <= 23) && (m <= 59) && (s <= 59);
      foreach (d[i]) if (i != 2 && i != 5 && d[i] > 9) ok = 0;
   endtask

   task automatic check_frame(input int nv0, input int ne0, input bit ok,
                              input int h, input int m, input int s);
      if (ok) begin
         exp_digits = fr_code;
         exp_dp     = fr_dp;
         exp_hh     = h;
         exp_mm     = m;
         exp_ss     = s;
         exp_stale  = 1'b0;
      end
      check("valid_pulses", nv - nv0, ok ? 1 : 0);
      check("err_pulses",   ne - ne0, ok ? 0 : 1);
      check("both_pulses",  n_both, 0);
      check("digits", digits, exp_digits);
      check("dp",     dp,     exp_dp);
      check("hh",     hh,     exp_hh);
      check("mm",     mm,     exp_mm);
      check("ss",     ss,     exp_ss);
      check("stale",  stale,  exp_stale);
   endtask

   task automatic run_frame(input bit ok, input int h, input int m, input int s, input int dwell);
      int nv0, ne0;
      nv0 = nv;
      ne0 = ne;
      scan(0, 8, dwell);
      idle(6);
      check_frame(nv0, ne0, ok, h, m, s);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fv"},     frame_valid, 1'b0);
      check({tag, "_fe"},     frame_err,   1'b0);
      check({tag, "_digits"}, digits, 32'hFFFF_FFFF);
      check({tag, "_dp"},     dp,     8'h00);
      check({tag, "_hh"},     hh,     5'd0);
      check({tag, "_mm"},     mm,     6'd0);
      check({tag, "_ss"},     ss,     6'd0);
      check({tag, "_stale"},  stale,  1'b1);
   endtask

   task automatic set_reset_expect();
      exp_digits = 32'hFFFF_FFFF;
      exp_dp     = 8'h00;
      exp_hh     = 0;
      exp_mm     = 0;
      exp_ss     = 0;
      exp_stale  = 1'b1;
   endtask

   initial begin
      int nv0, ne0;
      bit ok;
      int h, m, s;

      //          code (pos7..pos0)  dp      bad     ok  hh  mm  ss
      vecs[0] = '{32'h6504_3021, 8'h24, 7'h00, 1, 12, 34, 56};
      vecs[1] = '{32'h00F0_0F42, 8'h24, 7'h00, 0,  0,  0,  0};
      vecs[2] = '{32'h650E_3021, 8'h24, 7'h49, 0,  0,  0,  0};
      vecs[3] = '{32'h95F9_5F32, 8'h00, 7'h00, 1, 23, 59, 59};
      vecs[4] = '{32'h0000_0000, 8'hFF, 7'h00, 1,  0,  0,  0};
      vecs[5] = '{32'h00F0_6F32, 8'h00, 7'h00, 0,  0,  0,  0};
      vecs[6] = '{32'h70F5_0E90, 8'h81, 7'h11, 1,  9,  5,  7};
      vecs[7] = '{32'h03F5_4F91, 8'h24, 7'h00, 1, 19, 45, 30};
      vecs[8] = '{32'h00F0_0F5F, 8'h00, 7'h00, 0,  0,  0,  0};
      vecs[9] = '{32'h00F0_0F02, 8'h12, 7'h00, 1, 20,  0,  0};

      rst    = 1'b1;
      cs_in  = 8'hFF;
      seg_in = 8'hFF;
      set_reset_expect();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("stale_after_reset", stale, 1'b1);

      // Table-driven frames
      for (int v = 0; v < 10; v++) begin
         fr_code = vecs[v].code;
         fr_dp   = vecs[v].dpm;
         fr_bad  = vecs[v].bad;
         run_frame(vecs[v].ok, vecs[v].h, vecs[v].m, vecs[v].s, 30);
      end

      // Segment glitches: pos1 glitches then settles on a new value; pos3 glitches just before cs moves
      fr_code = 32'h83F7_2F31;
      fr_dp   = 8'h00;
      nv0 = nv;
      ne0 = ne;
      drive_pos(0, glyph_tab[1], 1'b0, 30);
      drive_pos(1, glyph_tab[4], 1'b0, 30);
      drive_pos(1, glyph_tab[8], 1'b0, 8);
      drive_pos(1, glyph_tab[3], 1'b0, 30);
      drive_pos(2, 7'h00, 1'b0, 30);
      drive_pos(3, glyph_tab[2], 1'b0, 30);
      drive_pos(3, glyph_tab[8], 1'b0, 8);
      scan(4, 4, 30);
      idle(6);
      check_frame(nv0, ne0, 1, 13, 27, 38);

      // Two digits selected at once must never be sampled
      fr_code = 32'h90F8_0F70;
      fr_dp   = 8'h00;
      nv0 = nv;
      ne0 = ne;
      cs_in  = 8'h00;
      seg_in = ~{1'b0, glyph_tab[5]};
      repeat (500) @(negedge clk);
      check("multi_cs_no_frame", (nv - nv0) + (ne - ne0), 0);
      scan(1, 7, 30);
      check("multi_cs_partial", (nv - nv0) + (ne - ne0), 0);
      scan(0, 1, 30);
      idle(6);
      check_frame(nv0, ne0, 1, 7, 8, 9);

      // Random frames against the reference model
      for (int r = 0; r < 14; r++) begin
         int hr, mn, sc;
         hr = $urandom_range(0, 29);
         mn = $urandom_range(0, 69);
         sc = $urandom_range(0, 69);
         fr_code = '0;
         fr_code[3:0]   = 4'(hr / 10);
         fr_code[7:4]   = 4'(hr % 10);
         fr_code[15:12] = 4'(mn / 10);
         fr_code[19:16] = 4'(mn % 10);
         fr_code[27:24] = 4'(sc / 10);
         fr_code[31:28] = 4'(sc % 10);
         fr_code[11:8]  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 9));
         fr_code[23:20] = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 9));
         fr_dp = 8'($urandom);
         fr_bad = 7'h49;
         if ($urandom_range(0, 3) == 0) begin
            bit hit;
            int bp;
            do begin
               fr_bad = 7'($urandom_range(1, 127));
               hit = 0;
               foreach (glyph_tab[g]) if (glyph_tab[g] == fr_bad) hit = 1;
            end while (hit);
            bp = $urandom_range(0, 7);
            fr_code[bp*4 +: 4] = 4'hE;
         end
         model(fr_code, ok, h, m, s);
         run_frame(ok, h, m, s, $urandom_range(25, 40));
      end

      // Timeout after a partial frame clears the mask and flags stale
      fr_code = 32'h6504_3021;
      fr_dp   = 8'h24;
      nv0 = nv;
      ne0 = ne;
      scan(0, 5, 30);
      idle(TMO - 100);
      check("stale_before_timeout", stale, 1'b0);
      idle(110);
      check("stale_after_timeout", stale, 1'b1);
      check("timeout_no_frame", (nv - nv0) + (ne - ne0), 0);
      exp_stale = 1'b1;
      fr_code = 32'h50F3_4F12;
      fr_dp   = 8'h00;
      scan(5, 3, 30);
      check("timeout_mask_cleared", (nv - nv0) + (ne - ne0), 0);
      scan(0, 5, 30);
      idle(6);
      check_frame(nv0, ne0, 1, 21, 43, 5);

      // Asynchronous reset while holding a partial frame
      fr_code = 32'h6504_3021;
      fr_dp   = 8'h24;
      scan(0, 5, 30);
      #2;
      rst    = 1'b1;
      cs_in  = 8'hFF;
      seg_in = 8'hFF;
      #1;
      check_reset_outputs("midframe_reset");
      set_reset_expect();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      fr_code = 32'h50F3_4F12;
      fr_dp   = 8'h00;
      nv0 = nv;
      ne0 = ne;
      scan(4, 4, 30);
      check("reset_mask_cleared", (nv - nv0) + (ne - ne0), 0);
      scan(0, 4, 30);
      idle(6);
      check_frame(nv0, ne0, 1, 21, 43, 5);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
